// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin writeback/io write arbiter with a zero-scrub sequencer
module regfile_write_arbiter #(
    parameter bit SCRUB_ON_RESET = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wb_req,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        wb_gnt,
    input  logic        io_req,
    input  logic [4:0]  io_addr,
    input  logic [31:0] io_data,
    output logic        io_gnt,
    input  logic        scrub_req,
    output logic        busy,
    output logic [31:0] reg_enable,
    output logic [31:0] reg_data
);
    typedef enum logic {IDLE, SCRUB} state_t;
    state_t      state, state_next;
    logic        last_io, last_io_next;
    logic [4:0]  scrub_addr, scrub_addr_next, sel_addr;
    logic [31:0] enable_next, data_next, sel_data;
    logic        can_grant;
    assign busy      = state == SCRUB;
    assign can_grant = state == IDLE && !reset && !scrub_req;
    assign wb_gnt    = can_grant && wb_req && (!io_req || last_io);
    assign io_gnt    = can_grant && io_req && (!wb_req || !last_io);
    assign sel_addr  = wb_gnt ? wb_addr : io_addr;
    assign sel_data  = wb_gnt ? wb_data : io_data;
    always_comb begin
        state_next      = state;
        scrub_addr_next = scrub_addr;
        last_io_next    = last_io;
        enable_next     = '0;
        data_next       = reg_data;
        if (state == SCRUB) begin
            enable_next     = 32'd1 << scrub_addr;
            data_next       = '0;
            scrub_addr_next = scrub_addr + 5'd1;
            state_next      = scrub_addr == 5'd31 ? IDLE : SCRUB;
        end else if (scrub_req) begin
            state_next      = SCRUB;
            scrub_addr_next = 5'd1;
        end else if (wb_gnt || io_gnt) begin
            enable_next  = sel_addr == 5'd0 ? '0 : 32'd1 << sel_addr;
            data_next    = sel_data;
            last_io_next = io_gnt;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= SCRUB_ON_RESET ? SCRUB : IDLE;
            scrub_addr <= 5'd1;
            last_io    <= 1'b1;
            reg_enable <= '0;
            reg_data   <= '0;
        end else begin
            state      <= state_next;
            scrub_addr <= scrub_addr_next;
            last_io    <= last_io_next;
            reg_enable <= enable_next;
            reg_data   <= data_next;
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: scoreboard bench; stimulus queues expected enables, monitor pops on nonzero reg_enable
module tb_regfile_write_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wb_req = 1'b0, io_req = 1'b0, scrub_req = 1'b0;
    logic [4:0]  wb_addr = '0, io_addr = '0;
    logic [31:0] wb_data = '0, io_data = '0;
    logic        wb_gnt, io_gnt, busy;
    logic [31:0] reg_enable, reg_data;
    typedef struct {
        int          cyc;
        logic [31:0] en;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    regfile_write_arbiter #(.SCRUB_ON_RESET(1'b1)) dut (
        .clock(clock), .reset(reset),
        .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_gnt(wb_gnt),
        .io_req(io_req), .io_addr(io_addr), .io_data(io_data), .io_gnt(io_gnt),
        .scrub_req(scrub_req), .busy(busy),
        .reg_enable(reg_enable), .reg_data(reg_data)
    );
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    task automatic push(input int c, input logic [4:0] a, input logic [31:0] d);
        exp_t        e;
        logic [31:0] one;
        one    = 32'd1;
        e.cyc  = c;
        e.en   = one << a;
        e.data = d;
        sb.push_back(e);
    endtask
    task automatic expect_scrub(input int base);
        for (int a = 1; a < 32; a++) push(base + a, 5'(a), 32'd0);
    endtask
    task automatic busy_run(input string name, input logic poke);
        int n;
        n = 0;
        while (busy && n < 40) begin
            check({name, "_wb_gnt"}, {31'd0, wb_gnt}, 32'd0);
            scrub_req = poke && n == 10;
            n++;
            @(negedge clock);
            scrub_req = 1'b0;
        end
        check({name, "_busy_cycles"}, n, 32'd31);
    endtask
    task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic i, input logic [4:0] ia, input logic [31:0] id,
                         input logic ew, input logic ei);
        wb_req = w; wb_addr = wa; wb_data = wd;
        io_req = i; io_addr = ia; io_data = id;
        #1;
        check("wb_gnt", {31'd0, wb_gnt}, {31'd0, ew});
        check("io_gnt", {31'd0, io_gnt}, {31'd0, ei});
        if (ew && wa != 5'd0) push(cyc + 1, wa, wd);
        if (ei && ia != 5'd0) push(cyc + 1, ia, id);
        @(negedge clock);
    endtask
    always @(negedge clock) begin
        if (reg_enable !== 32'd0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_enable actual=%h required=00000000 (cycle %0d)", reg_enable, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("enable_cycle", cyc, e.cyc);
                check("reg_enable", reg_enable, e.en);
                check("reg_data", reg_data, e.data);
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int c0;
        wb_req = 1'b1; wb_addr = 5'd4; wb_data = 32'h1;
        repeat (3) @(negedge clock);
        check("rst_enable", reg_enable, 32'd0);
        check("rst_data", reg_data, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_wb_gnt", {31'd0, wb_gnt}, 32'd0);
        wb_req = 1'b0;
        reset  = 1'b0;
        expect_scrub(cyc);
        busy_run("init_scrub", 1'b0);
        drive(1, 5'd3, 32'h0000_0333, 1, 5'd7, 32'h0000_0777, 1, 0);
        drive(1, 5'd3, 32'h0000_0333, 1, 5'd7, 32'h0000_0777, 0, 1);
        drive(1, 5'd3, 32'h0000_0333, 1, 5'd7, 32'h0000_0777, 1, 0);
        drive(1, 5'd3, 32'h0000_0333, 1, 5'd7, 32'h0000_0777, 0, 1);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
        drive(1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 32'h0, 1, 0);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
        check("wb_enable_clears", reg_enable, 32'd0);
        drive(0, 5'd0, 32'h0, 1, 5'd0, 32'h1234_5678, 0, 1);
        check("addr0_enable", reg_enable, 32'd0);
        check("addr0_data", reg_data, 32'h1234_5678);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
        c0 = cyc;
        wb_req = 1'b1; wb_addr = 5'd9; wb_data = 32'hAAAA_5555;
        scrub_req = 1'b1;
        #1;
        check("scrub_start_wb_gnt", {31'd0, wb_gnt}, 32'd0);
        check("scrub_start_io_gnt", {31'd0, io_gnt}, 32'd0);
        expect_scrub(c0 + 1);
        @(negedge clock);
        scrub_req = 1'b0;
        busy_run("req_scrub", 1'b1);
        #1;
        check("post_scrub_wb_gnt", {31'd0, wb_gnt}, 32'd1);
        push(cyc + 1, 5'd9, 32'hAAAA_5555);
        @(negedge clock);
        wb_req = 1'b0;
        repeat (2) @(negedge clock);
        c0 = cyc;
        scrub_req = 1'b1;
        for (int a = 1; a < 16; a++) push(c0 + 1 + a, 5'(a), 32'd0);
        @(negedge clock);
        scrub_req = 1'b0;
        repeat (15) @(negedge clock);
        check("mid_scrub_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_enable", reg_enable, 32'd0);
        @(negedge clock);
        check("mid_rst_enable2", reg_enable, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        expect_scrub(cyc);
        busy_run("restart_scrub", 1'b0);
        repeat (3) @(negedge clock);
        check("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
